bias_seq_ctrl: RTL and testbench
================================

# bias_seq_ctrl

Sequencer for a layer's bias coefficient ROM. On each `ap_start` it walks ROM addresses `0..KERN-1`, repeating the walk `REPS` times, and pushes every coefficient into the downstream bias FIFO through the standard `din`/`full_n`/`write` handshake. An internal two-entry skid buffer absorbs the ROM's one-cycle read latency, so back-pressure never loses or duplicates a word. It sits between the synchronous `rom` instance and the convolution core's bias input stream, replacing the HLS-generated bias streamer.

## Interface
Parameters:
- `KERN`, 16: number of bias words (output channels); must be ≥1.
- `COEFF_WIDTH`, 16: bias word width.
- `REPS`, 1: full passes over the ROM per start; must be ≥1.
- `AW`, `$clog2(KERN)` (minimum 1): ROM address width.

Ports:
- `ap_clk`, in, 1: the single clock; all logic is on the rising edge.
- `ap_rst`, in, 1: synchronous, active-high reset.
- `ap_start`, in, 1: start request; sampled only while idle.
- `ap_idle`, out, 1: high while in IDLE.
- `ap_done`, out, 1: one-cycle pulse when the job completes.
- `ap_ready`, out, 1: one-cycle pulse, coincident with `ap_done`.
- `bias_address`, out, AW: ROM address.
- `bias_ce`, out, 1: ROM read enable.
- `bias_q`, in, COEFF_WIDTH: ROM data; valid the cycle after `bias_ce`.
- `output_V_din`, out, COEFF_WIDTH: word presented to the FIFO.
- `output_V_full_n`, in, 1: FIFO has space.
- `output_V_write`, out, 1: push strobe.
- `stall_cnt`, out, 32: present only with `BIAS_SEQ_STALL_CNT_EN`.

## Operation
- FSM states and transitions:
  - IDLE → RUN on `ap_start`.
  - RUN → DRAIN after the last read is issued (address `KERN-1`, pass `REPS-1`).
  - DRAIN → DONE when the skid buffer is empty and no read is in flight.
  - DONE → IDLE unconditionally after one cycle.
- Read issue: `bias_ce` is high in RUN only when (in-flight read + buffer occupancy) < 2. Without this credit rule the buffer could overflow.
- Address counter: increments on each issued read and wraps `KERN-1` → 0. The pass counter increments on each wrap.
- Capture: data returned on `bias_q` is written into the 2-entry FIFO buffer in the cycle after the issue.
- Output: `output_V_write = buffer_nonempty & output_V_full_n`; `output_V_din` = buffer head. A word pops when `write` is high.
- Simultaneous capture and pop: the buffer keeps the same occupancy, and ordering is preserved.
- `ap_start` in any state other than IDLE is ignored; it is not queued.
- Total words written per job is exactly `KERN*REPS`, in address order, pass by pass.
- `KERN=1`: the address stays 0, and each pass is a single read.

## Timing
- Reset values: `ap_idle`=1; all other outputs (`ap_done`, `ap_ready`, `bias_ce`, `bias_address`, `output_V_write`, `output_V_din`) are 0; `stall_cnt`=0; buffer empty; FSM in IDLE.
- Start at cycle 0 (IDLE, `ap_start`=1):
  - Cycle 1: `bias_ce`=1, address 0.
  - Cycle 2: ROM data returns and is captured.
  - Cycle 3: first `output_V_write`.
- Throughput: one word per cycle while `full_n` stays high. With no stalls the last write lands in cycle `KERN*REPS+2`, and `ap_done`/`ap_ready` pulse in cycle `KERN*REPS+3`.
- `full_n` low: `write` drops in the same cycle (combinational), and issue stops once the credit is exhausted. At most 2 words are held.
- `ap_rst` mid-job: on the next edge everything returns to reset values, and in-flight ROM data is discarded.

## Configuration
- `BIAS_SEQ_STALL_CNT_EN` defined: adds the `stall_cnt` port.
  - Counts cycles with buffer nonempty and `output_V_full_n`=0.
  - Cleared on `ap_rst` and on each accepted `ap_start`.
  - Saturates at all-ones.
- Not defined: the port and counter do not exist; all other behaviour is identical.

## Structure
- The shared package/header (`layers_sizes.vh`/`my_types.vh` family) holds the FSM state encoding constants and the `coeff_width` default.
- One sub-module: `bias_skid_buf`, a 2-entry synchronous FIFO with push/pop/count. The parent holds the FSM, the counters and the credit logic.

## Test plan
- `KERN=4`, `REPS=1`, ROM = {0x11,0x22,0x33,0x44}, `full_n`=1 → writes 0x11..0x44 in cycles 3–6; `ap_done` pulses in cycle 7; `ap_idle` is 1 in cycle 8.
- `KERN=3`, `REPS=2` → six writes, sequence 0,1,2,0,1,2 by address; the address wraps without a gap.
- `full_n` low for cycles 4–8 → no writes in 4–8, at most 2 buffered words, no loss or duplication. With the macro on, `stall_cnt`=5.
- `ap_start` pulsed again in cycle 2 during a job → ignored; exactly `KERN*REPS` words are written.
- `ap_rst` asserted in cycle 4 of a job → the next cycle shows reset values. A fresh start then writes the full sequence from address 0.
- `KERN=1`, `REPS=3`, `full_n` toggling every cycle → three writes of word 0, then `ap_done`.

Source files
------------

// File: rtl/bias_seq_ctrl_pkg.sv
// Shared definitions for the bias coefficient sequencer: FSM state encoding,
// default coefficient width and a width helper.
package bias_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bias_state_t;

  localparam int unsigned COEFF_WIDTH_DEFAULT = 16;
  localparam int unsigned SKID_DEPTH          = 2;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bias_seq_ctrl_skid.sv
// Two-entry synchronous FIFO that absorbs the ROM read latency in front of
// the bias output stream. Push while full (without a pop) and pop while empty are ignored.
module bias_skid_buf
  import bias_seq_ctrl_pkg::*;
#(
  parameter int unsigned W = COEFF_WIDTH_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_count,
  output logic         o_empty
);

  logic [W-1:0] r_mem [SKID_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = i_pop & (r_count != 2'd0);
  assign w_push = i_push & ((r_count != 2'd2) | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/bias_seq_ctrl.sv
// Bias ROM sequencer: walks addresses 0..KERN-1 REPS times per ap_start and
// streams the words into the bias FIFO. Optional stall counter: BIAS_SEQ_STALL_CNT_EN.
module bias_seq_ctrl
  import bias_seq_ctrl_pkg::*;
#(
  parameter int unsigned KERN        = 16,
  parameter int unsigned COEFF_WIDTH = COEFF_WIDTH_DEFAULT,
  parameter int unsigned REPS        = 1,
  parameter int unsigned AW          = min1_clog2(KERN)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic                   ap_start,
  output logic                   ap_idle,
  output logic                   ap_done,
  output logic                   ap_ready,
  output logic [AW-1:0]          bias_address,
  output logic                   bias_ce,
  input  logic [COEFF_WIDTH-1:0] bias_q,
  output logic [COEFF_WIDTH-1:0] output_V_din,
  input  logic                   output_V_full_n,
  output logic                   output_V_write
`ifdef BIAS_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]            stall_cnt
`endif
);

  localparam int unsigned    PW        = min1_clog2(REPS);
  localparam logic [AW-1:0]  ADDR_LAST = AW'(KERN - 1);
  localparam logic [PW-1:0]  PASS_LAST = PW'(REPS - 1);

  bias_state_t r_state;
  bias_state_t w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [PW-1:0] r_pass;
  logic          r_inflight;
  logic [1:0]    w_count;
  logic          w_empty;
  logic          w_pop;
  logic          w_issue;
  logic          w_start_acc;
  logic [2:0]    w_occ;

  bias_skid_buf #(
    .W (COEFF_WIDTH)
  ) u_skid (
    .i_clk   (ap_clk),
    .i_rst   (ap_rst),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_din   (bias_q),
    .o_dout  (output_V_din),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign w_pop          = ~w_empty & output_V_full_n;
  assign output_V_write = w_pop;

  // Occupancy seen by the next capture: the same-cycle pop is credited back so
  // issue can continue every cycle while the FIFO accepts.
  assign w_occ = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_inflight};

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_start_acc = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ap_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_issue = (w_occ < 3'd2);
        if (w_issue && (r_addr == ADDR_LAST) && (r_pass == PASS_LAST)) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_occ == 3'd0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_pass     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_start_acc) begin
        r_addr <= '0;
        r_pass <= '0;
      end else if (w_issue) begin
        if (r_addr == ADDR_LAST) begin
          r_addr <= '0;
          r_pass <= (r_pass == PASS_LAST) ? '0 : r_pass + PW'(1);
        end else begin
          r_addr <= r_addr + AW'(1);
        end
      end
    end
  end

  assign ap_idle      = (r_state == ST_IDLE);
  assign ap_done      = (r_state == ST_DONE);
  assign ap_ready     = (r_state == ST_DONE);
  assign bias_address = r_addr;
  assign bias_ce      = w_issue;

`ifdef BIAS_SEQ_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge ap_clk) begin
    if (ap_rst || w_start_acc) begin
      r_stall_cnt <= '0;
    end else if (!w_empty && !output_V_full_n && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_bias_seq_ctrl.sv
// Directed bench for bias_seq_ctrl: cycle tables for the basic and stalled
// jobs, plus hand sequences for restart, reset, multi-pass and KERN=1 cases.
module tb_bias_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic rst = 1'b1;

  // DUT A: KERN=4, REPS=1
  logic        start_a = 1'b0, full_a = 1'b1;
  logic        idle_a, done_a, ready_a, ce_a, wr_a;
  logic [1:0]  addr_a;
  logic [15:0] q_a, din_a;
  logic [15:0] rom_a [4];
  // DUT B: KERN=3, REPS=2
  logic        start_b = 1'b0, full_b = 1'b1;
  logic        idle_b, done_b, ready_b, ce_b, wr_b;
  logic [1:0]  addr_b;
  logic [15:0] q_b, din_b;
  logic [15:0] rom_b [3];
  // DUT C: KERN=1, REPS=3
  logic        start_c = 1'b0, full_c = 1'b1;
  logic        idle_c, done_c, ready_c, ce_c, wr_c;
  logic [0:0]  addr_c;
  logic [15:0] q_c, din_c;
`ifdef BIAS_SEQ_STALL_CNT_EN
  logic [31:0] stall_a, stall_b, stall_c;
`endif

  bias_seq_ctrl #(.KERN(4), .COEFF_WIDTH(16), .REPS(1), .AW(2)) u_dut_a (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_a), .ap_idle(idle_a),
    .ap_done(done_a), .ap_ready(ready_a), .bias_address(addr_a), .bias_ce(ce_a),
    .bias_q(q_a), .output_V_din(din_a), .output_V_full_n(full_a), .output_V_write(wr_a)
`ifdef BIAS_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_a)
`endif
  );

  bias_seq_ctrl #(.KERN(3), .COEFF_WIDTH(16), .REPS(2), .AW(2)) u_dut_b (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_b), .ap_idle(idle_b),
    .ap_done(done_b), .ap_ready(ready_b), .bias_address(addr_b), .bias_ce(ce_b),
    .bias_q(q_b), .output_V_din(din_b), .output_V_full_n(full_b), .output_V_write(wr_b)
`ifdef BIAS_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_b)
`endif
  );

  bias_seq_ctrl #(.KERN(1), .COEFF_WIDTH(16), .REPS(3), .AW(1)) u_dut_c (
    .ap_clk(clk), .ap_rst(rst), .ap_start(start_c), .ap_idle(idle_c),
    .ap_done(done_c), .ap_ready(ready_c), .bias_address(addr_c), .bias_ce(ce_c),
    .bias_q(q_c), .output_V_din(din_c), .output_V_full_n(full_c), .output_V_write(wr_c)
`ifdef BIAS_SEQ_STALL_CNT_EN
    , .stall_cnt(stall_c)
`endif
  );

  // Synchronous ROM models: data valid the cycle after ce.
  always @(posedge clk) begin
    if (ce_a) q_a <= rom_a[addr_a];
    if (ce_b) q_b <= rom_b[addr_b];
    if (ce_c) q_c <= 16'h005A;
  end

  logic [15:0] log_a[$], log_b[$], log_c[$];
  int          logcyc_b[$];
  always @(negedge clk) begin
    if (wr_a === 1'b1) log_a.push_back(din_a);
    if (wr_b === 1'b1) begin
      log_b.push_back(din_b);
      logcyc_b.push_back(cyc);
    end
    if (wr_c === 1'b1) log_c.push_back(din_c);
  end

  typedef struct {
    logic        rst, start, full_n, chk;
    logic        idle, done, ce;
    logic [1:0]  addr;
    logic        wr;
    logic [15:0] din;
    logic        chk_din;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int r, int s, int f, int c, int id, int dn,
                              int ce, int ad, int wr, int din, int cd);
    vec_t v;
    v.rst = r[0]; v.start = s[0]; v.full_n = f[0]; v.chk = c[0];
    v.idle = id[0]; v.done = dn[0]; v.ce = ce[0]; v.addr = ad[1:0];
    v.wr = wr[0]; v.din = din[15:0]; v.chk_din = cd[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits at negedges for ap_done of the chosen DUT; returns the cycle it was seen.
  task automatic wait_done(input int which, input int lim, output int seen_cyc);
    seen_cyc = -1;
    for (int k = 0; k < lim; k++) begin
      @(negedge clk);
      if ((which == 0 && done_a === 1'b1) || (which == 1 && done_b === 1'b1) ||
          (which == 2 && done_c === 1'b1)) begin
        seen_cyc = cyc;
        break;
      end
    end
    chk($sformatf("done_timeout_dut%0d", which), 32'(seen_cyc >= 0), 32'd1);
  endtask

  initial begin
    int s, dcyc;
    rom_a[0] = 16'h0011; rom_a[1] = 16'h0022; rom_a[2] = 16'h0033; rom_a[3] = 16'h0044;
    rom_b[0] = 16'h00A0; rom_b[1] = 16'h00A1; rom_b[2] = 16'h00A2;

    //          rst st fn chk idle done ce ad wr din  cd
    tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0,    1));
    // basic job, cycles 0..8
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 0,    0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 2, 1, 'h11, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 3, 1, 'h22, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 'h33, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 'h44, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0,    0));
    // stalled job: full_n low in cycles 4..8
    tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 0,    0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 2, 1, 'h11, 1));
    for (int i = 4; i <= 8; i++)
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3, 0, 0,  0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 3, 1, 'h22, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 'h33, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 'h44, 1));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0,    0));
    tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0,    0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst; start_a = tbl[i].start; full_a = tbl[i].full_n;
      @(negedge clk);
      if (tbl[i].chk) begin
        chk($sformatf("row%0d idle", i),  32'(idle_a),  32'(tbl[i].idle));
        chk($sformatf("row%0d done", i),  32'(done_a),  32'(tbl[i].done));
        chk($sformatf("row%0d ready", i), 32'(ready_a), 32'(tbl[i].done));
        chk($sformatf("row%0d ce", i),    32'(ce_a),    32'(tbl[i].ce));
        chk($sformatf("row%0d addr", i),  32'(addr_a),  32'(tbl[i].addr));
        chk($sformatf("row%0d write", i), 32'(wr_a),    32'(tbl[i].wr));
        if (tbl[i].chk_din)
          chk($sformatf("row%0d din", i), 32'(din_a),   32'(tbl[i].din));
      end
      step();
    end
    full_a = 1'b1;
`ifdef BIAS_SEQ_STALL_CNT_EN
    chk("stall_cnt", stall_a, 32'd5);
`endif

    // Second start pulse mid-job is ignored.
    log_a.delete();
    start_a = 1'b1; step();
    start_a = 1'b0; step();
    start_a = 1'b1; step();
    start_a = 1'b0;
    wait_done(0, 40, dcyc);
    for (int k = 0; k < 10; k++) @(negedge clk);
    chk("restart_idle", 32'(idle_a), 32'd1);
    chk("restart_nwords", 32'(log_a.size()), 32'd4);
    for (int k = 0; k < 4 && k < log_a.size(); k++)
      chk($sformatf("restart_word%0d", k), 32'(log_a[k]), 32'(rom_a[k]));
    step();

    // Reset asserted in cycle 4 of a job.
    log_a.delete();
    start_a = 1'b1; step();
    start_a = 1'b0; step();
    step();
    step();
    rst = 1'b1; step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_idle",  32'(idle_a), 32'd1);
    chk("rst_done",  32'(done_a), 32'd0);
    chk("rst_ce",    32'(ce_a),   32'd0);
    chk("rst_addr",  32'(addr_a), 32'd0);
    chk("rst_write", 32'(wr_a),   32'd0);
    chk("rst_din",   32'(din_a),  32'd0);
    step();
    @(negedge clk);
    chk("rst_discard_write", 32'(wr_a), 32'd0);
    chk("rst_prior_words", 32'(log_a.size()), 32'd2);
    step();
    log_a.delete();
    start_a = 1'b1; step();
    start_a = 1'b0;
    wait_done(0, 40, dcyc);
    chk("post_rst_nwords", 32'(log_a.size()), 32'd4);
    for (int k = 0; k < 4 && k < log_a.size(); k++)
      chk($sformatf("post_rst_word%0d", k), 32'(log_a[k]), 32'(rom_a[k]));
    step();

    // KERN=3, REPS=2: six back-to-back writes across the wrap.
    log_b.delete(); logcyc_b.delete();
    s = cyc;
    start_b = 1'b1; step();
    start_b = 1'b0;
    wait_done(1, 40, dcyc);
    chk("b_done_cycle", 32'(dcyc - s), 32'd9);
    chk("b_ready", 32'(ready_b), 32'd1);
    chk("b_nwords", 32'(log_b.size()), 32'd6);
    for (int k = 0; k < 6 && k < log_b.size(); k++) begin
      chk($sformatf("b_word%0d", k), 32'(log_b[k]), 32'(rom_b[k % 3]));
      chk($sformatf("b_cycle%0d", k), 32'(logcyc_b[k] - s), 32'(k + 3));
    end
    step();

    // KERN=1, REPS=3 with full_n toggling every cycle.
    log_c.delete();
    dcyc = -1;
    for (int k = 0; k < 60; k++) begin
      start_c = (k == 0);
      full_c  = k[0];
      @(negedge clk);
      if (done_c === 1'b1) begin
        dcyc = k;
        break;
      end
      step();
    end
    chk("c_done_seen", 32'(dcyc >= 0), 32'd1);
    chk("c_nwords", 32'(log_c.size()), 32'd3);
    for (int k = 0; k < 3 && k < log_c.size(); k++)
      chk($sformatf("c_word%0d", k), 32'(log_c[k]), 32'h5A);
    chk("c_addr", 32'(addr_c), 32'd0);
    full_c = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
